mvm_uart_ctrl: RTL and testbench
================================

MVM_UART_CTRL -- requirements
Module: mvm_uart_ctrl

Interface
REQ-001 SHALL have parameter R, default 2, meaning number of output rows (Y elements).
REQ-002 SHALL have parameter C, default 2, meaning number of columns (X elements).
REQ-003 SHALL have parameter W_K, default 4, meaning weight element width in bits.
REQ-004 SHALL have parameter W_X, default 4, meaning input element width in bits.
REQ-005 SHALL have parameter W_Y_OUT, default 8, meaning result element width in bits; legal range is 1..8.
REQ-006 SHALL have parameter TIMEOUT_CYCLES, default 1000, meaning the maximum allowed idle gap between received bytes.
REQ-007 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-008 SHALL have port rstn, input, 1 bit: reset, synchronous and active-low.
REQ-009 SHALL have port rx_data, input, 8 bits: byte from the UART receiver.
REQ-010 SHALL have port rx_valid, input, 1 bit: one-cycle strobe qualifying rx_data.
REQ-011 SHALL have port k_out, output, R*C*W_K bits: weight matrix, element (r,c) at index r*C+c, LSB-first.
REQ-012 SHALL have port x_out, output, C*W_X bits: input vector, element c at index c.
REQ-013 SHALL have port mvm_valid, output, 1 bit: K/X operands valid, start request.
REQ-014 SHALL have port mvm_ready, input, 1 bit: datapath accepts operands.
REQ-015 SHALL have port y_in, input, R*W_Y_OUT bits: result vector.
REQ-016 SHALL have port y_valid, input, 1 bit: one-cycle strobe qualifying y_in.
REQ-017 SHALL have port tx_data, output, 8 bits: byte to the UART transmitter.
REQ-018 SHALL have port tx_valid, output, 1 bit: tx_data valid.
REQ-019 SHALL have port tx_ready, input, 1 bit: transmitter accepts the byte.
REQ-020 SHALL have port busy, output, 1 bit: high in every state except S_RECV.
REQ-021 SHALL have port err_timeout, output, 1 bit: one-cycle pulse on a frame timeout.

Function
REQ-022 SHALL implement the FSM S_RECV -> S_START -> S_WAIT -> S_SEND -> S_RECV.
REQ-023 In S_RECV, each rx_valid SHALL store the low bits of rx_data at byte index n and increment n.
- Indices 0..R*C-1 fill K.
- Indices R*C..R*C+C-1 fill X.
REQ-024 On acceptance of byte R*C+C-1, SHALL clear n and enter S_START; mvm_valid is asserted the next cycle.
REQ-025 In S_START, SHALL hold mvm_valid high with k_out/x_out stable until the cycle mvm_ready=1, then enter S_WAIT; mvm_valid is 0 from the following cycle.
REQ-026 In S_WAIT, on y_valid SHALL latch y_in and enter S_SEND; tx_valid is high the next cycle carrying element 0.
REQ-027 In S_SEND, SHALL send elements 0..R-1 in order, each zero-extended to 8 bits.
- tx_data is held stable while tx_valid=1 and tx_ready=0.
- A byte completes when tx_valid=1 and tx_ready=1.
- The next element follows in the next cycle, with no bubble.
REQ-028 Completion of element R-1 SHALL drop tx_valid and return to S_RECV in the next cycle.
REQ-029 SHALL ignore and discard rx_valid outside S_RECV; K, X and n are unchanged.
REQ-030 SHALL ignore y_valid outside S_WAIT.
REQ-031 k_out/x_out SHALL retain their last loaded values until overwritten byte by byte.

Reset
REQ-032 rstn=0 at a rising edge SHALL force the following, regardless of the current state (including mid-frame or mid-send):
- state S_RECV;
- n=0;
- k_out, x_out and the Y latch all 0;
- mvm_valid=0, tx_valid=0, tx_data=0, busy=0, err_timeout=0.

Configuration
REQ-033 The macro MVM_CTRL_TIMEOUT_EN, when defined, SHALL enable the idle-gap timer.
- The timer counts cycles in S_RECV with n>0 and no rx_valid.
- It clears on every rx_valid.
- On reaching TIMEOUT_CYCLES it sets n=0, pulses err_timeout for 1 cycle, and clears itself.
REQ-034 When MVM_CTRL_TIMEOUT_EN is undefined, SHALL instantiate no timer logic, keep err_timeout constant 0, and let a partial frame wait indefinitely.

Verification
REQ-035 Full frame: send bytes 1,2,3,4,5,6 with mvm_ready=1.
- k_out elements must equal (1,2,3,4) and x_out elements (5,6).
- mvm_valid must be high exactly 1 cycle, starting the cycle after byte 6.
REQ-036 Backpressure on start: hold mvm_ready=0 for 5 cycles after the frame.
- mvm_valid must stay high for 6 cycles with stable operands.
- busy must stay 1.
REQ-037 Result send: y_in={8'hA5,8'h3C}, with tx_ready low for 3 cycles on the first byte.
- Must send 8'h3C held for 4 cycles, then 8'hA5.
- Must return to S_RECV with busy=0 one cycle after the last handshake.
REQ-038 Rx bytes injected during S_WAIT must not alter k_out/x_out; the next frame must load normally from index 0.
REQ-039 Assert rstn=0 for 1 cycle after 3 bytes, or during S_SEND. All REQ-032 outputs must read reset values the next cycle, and a fresh 6-byte frame must succeed.
REQ-040 With MVM_CTRL_TIMEOUT_EN and TIMEOUT_CYCLES=20: send 2 bytes, then idle 20 cycles.
- err_timeout must pulse once and n must return to 0.
- Without the macro, err_timeout must stay 0 and the next 4 bytes must complete the frame.

Source files
------------

// File: rtl/mvm_uart_ctrl.sv
// UART-framed operand loader / result sender around a matrix-vector datapath; frame ends -> mvm_valid next cycle.
// Optional idle-gap frame timeout under MVM_CTRL_TIMEOUT_EN; start and result bytes wait on mvm_ready / tx_ready.
module mvm_uart_ctrl #(
    parameter int R              = 2,
    parameter int C              = 2,
    parameter int W_K            = 4,
    parameter int W_X            = 4,
    parameter int W_Y_OUT        = 8,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    output logic [R*C*W_K-1:0]     k_out,
    output logic [C*W_X-1:0]       x_out,
    output logic                   mvm_valid,
    input  logic                   mvm_ready,
    input  logic [R*W_Y_OUT-1:0]   y_in,
    input  logic                   y_valid,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic                   busy,
    output logic                   err_timeout
);

    localparam int NB = R*C + C;
    localparam int NW = $clog2(NB + 1);
    localparam int IW = (R > 1) ? $clog2(R) : 1;

    typedef enum logic [1:0] {S_RECV, S_START, S_WAIT, S_SEND} state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [NW-1:0]          r_n;
    logic [R*C*W_K-1:0]     r_k;
    logic [C*W_X-1:0]       r_x;
    logic [R*W_Y_OUT-1:0]   r_y;
    logic [IW-1:0]          r_idx;
    logic [W_Y_OUT-1:0]     w_y_elem;
    logic                   w_rx_acc;
    logic                   w_last_byte;
    logic                   w_tx_done;
    logic                   w_last_tx;
    logic                   w_timeout;
    logic                   w_rx_unused;

    // Only the low W_K/W_X bits of each byte carry payload.
    assign w_rx_unused = ^rx_data;

    assign w_rx_acc    = (r_state == S_RECV) && rx_valid;
    assign w_last_byte = w_rx_acc && (r_n == NW'(NB - 1));
    assign w_tx_done   = (r_state == S_SEND) && tx_ready;
    assign w_last_tx   = w_tx_done && (r_idx == IW'(R - 1));

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= S_RECV;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RECV:  if (w_last_byte) w_state_nxt = S_START;
            S_START: if (mvm_ready)   w_state_nxt = S_WAIT;
            S_WAIT:  if (y_valid)     w_state_nxt = S_SEND;
            S_SEND:  if (w_last_tx)   w_state_nxt = S_RECV;
            default:                  w_state_nxt = S_RECV;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_n   <= '0;
            r_k   <= '0;
            r_x   <= '0;
            r_y   <= '0;
            r_idx <= '0;
        end else begin
            if (w_rx_acc) begin
                for (int i = 0; i < R*C; i++) begin
                    if (r_n == NW'(i)) r_k[i*W_K +: W_K] <= rx_data[W_K-1:0];
                end
                for (int c = 0; c < C; c++) begin
                    if (r_n == NW'(R*C + c)) r_x[c*W_X +: W_X] <= rx_data[W_X-1:0];
                end
                r_n <= w_last_byte ? '0 : r_n + 1'b1;
            end else if (w_timeout) begin
                r_n <= '0;
            end

            if ((r_state == S_WAIT) && y_valid) begin
                r_y   <= y_in;
                r_idx <= '0;
            end else if (w_tx_done) begin
                r_idx <= w_last_tx ? '0 : r_idx + 1'b1;
            end
        end
    end

    always_comb begin
        w_y_elem = '0;
        for (int i = 0; i < R; i++) begin
            if (r_idx == IW'(i)) w_y_elem = r_y[i*W_Y_OUT +: W_Y_OUT];
        end
    end

`ifdef MVM_CTRL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] r_to_cnt;
    logic          r_err;

    // Fires on the idle cycle that would bring the gap count to TIMEOUT_CYCLES.
    assign w_timeout = (r_state == S_RECV) && !rx_valid && (r_n != '0)
                       && (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_to_cnt <= '0;
            r_err    <= 1'b0;
        end else begin
            r_err <= w_timeout;
            if (rx_valid || w_timeout || (r_state != S_RECV) || (r_n == '0)) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
        end
    end

    assign err_timeout = r_err;
`else
    logic w_cfg_unused;

    assign w_cfg_unused = (TIMEOUT_CYCLES > 0);
    assign w_timeout    = 1'b0;
    assign err_timeout  = 1'b0;
`endif

    assign k_out     = r_k;
    assign x_out     = r_x;
    assign mvm_valid = (r_state == S_START);
    assign tx_valid  = (r_state == S_SEND);
    assign tx_data   = (r_state == S_SEND) ? 8'(w_y_elem) : 8'h00;
    assign busy      = (r_state != S_RECV);

endmodule

// File: tb/tb_mvm_uart_ctrl.sv
// Directed + randomized bench for mvm_uart_ctrl (R=C=2, 4-bit K/X, 8-bit Y, timeout 20 cycles).
module tb_mvm_uart_ctrl;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic [15:0] k_out;
    logic [7:0]  x_out;
    logic        mvm_valid;
    logic        mvm_ready = 1'b0;
    logic [15:0] y_in = 16'h0000;
    logic        y_valid = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        busy;
    logic        err_timeout;

    mvm_uart_ctrl #(
        .R(2), .C(2), .W_K(4), .W_X(4), .W_Y_OUT(8), .TIMEOUT_CYCLES(20)
    ) dut (
        .clk(clk), .rstn(rstn),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .k_out(k_out), .x_out(x_out),
        .mvm_valid(mvm_valid), .mvm_ready(mvm_ready),
        .y_in(y_in), .y_valid(y_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [7:0]  fr [6];
    logic [15:0] exp_k;
    logic [7:0]  exp_x;
    logic [7:0]  exp_q [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
    endtask

    task automatic send_range(input int s, input int e);
        for (int i = s; i < e; i++) send_byte(fr[i]);
    endtask

    task automatic rand_frame();
        for (int i = 0; i < 6; i++) fr[i] = 8'($urandom);
    endtask

    // Reference: bytes 0..3 are K elements (r*C+c), bytes 4..5 are X, low nibble only.
    task automatic model_frame();
        for (int i = 0; i < 4; i++) exp_k[i*4 +: 4] = fr[i][3:0];
        for (int c = 0; c < 2; c++) exp_x[c*4 +: 4] = fr[4+c][3:0];
    endtask

    task automatic check_reset_outs(input string tag);
        chk({tag, "_k"}, 64'(k_out), 64'h0);
        chk({tag, "_x"}, 64'(x_out), 64'h0);
        chk({tag, "_mvm_valid"}, 64'(mvm_valid), 64'h0);
        chk({tag, "_tx_valid"}, 64'(tx_valid), 64'h0);
        chk({tag, "_tx_data"}, 64'(tx_data), 64'h0);
        chk({tag, "_busy"}, 64'(busy), 64'h0);
        chk({tag, "_err"}, 64'(err_timeout), 64'h0);
    endtask

    // In S_START: random mvm_ready until the handshake, operands must stay put.
    task automatic do_start(input string tag);
        bit done = 1'b0;
        for (int cyc = 0; cyc < 50 && !done; cyc++) begin
            mvm_ready = 1'($urandom);
            chk({tag, "_mvm_valid_hi"}, 64'(mvm_valid), 64'h1);
            chk({tag, "_k_stable"}, 64'(k_out), 64'(exp_k));
            chk({tag, "_x_stable"}, 64'(x_out), 64'(exp_x));
            done = mvm_ready;
            tick();
        end
        mvm_ready = 1'b0;
        chk({tag, "_start_done"}, 64'(done), 64'h1);
        chk({tag, "_mvm_valid_lo"}, 64'(mvm_valid), 64'h0);
    endtask

    // In S_WAIT: deliver y, then drain bytes with random tx_ready.
    task automatic do_result(input string tag, input logic [15:0] y);
        y_in    = y;
        y_valid = 1'b1;
        tick();
        y_valid = 1'b0;
        y_in    = 16'($urandom);
        exp_q   = {y[7:0], y[15:8]};
        for (int cyc = 0; cyc < 200 && exp_q.size() > 0; cyc++) begin
            tx_ready = 1'($urandom);
            chk({tag, "_tx_valid"}, 64'(tx_valid), 64'h1);
            chk({tag, "_tx_data"}, 64'(tx_data), 64'(exp_q[0]));
            if (tx_ready) void'(exp_q.pop_front());
            tick();
        end
        tx_ready = 1'b0;
        chk({tag, "_drained"}, 64'(exp_q.size()), 64'h0);
        chk({tag, "_tx_valid_end"}, 64'(tx_valid), 64'h0);
        chk({tag, "_busy_end"}, 64'(busy), 64'h0);
    endtask

    initial begin
        int pulses;
        logic [15:0] k_keep;
        logic [7:0]  x_keep;

        // Reset state
        rstn = 1'b0;
        tick();
        tick();
        check_reset_outs("reset");
        rstn = 1'b1;
        tick();

        // Full frame 1..6, mvm_ready high
        mvm_ready = 1'b1;
        fr = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6};
        send_range(0, 5);
        chk("ff_mvm_valid_pre", 64'(mvm_valid), 64'h0);
        chk("ff_busy_pre", 64'(busy), 64'h0);
        send_byte(fr[5]);
        chk("ff_mvm_valid", 64'(mvm_valid), 64'h1);
        chk("ff_busy", 64'(busy), 64'h1);
        chk("ff_k", 64'(k_out), 64'h4321);
        chk("ff_x", 64'(x_out), 64'h65);
        tick();
        mvm_ready = 1'b0;
        chk("ff_mvm_valid_1cyc", 64'(mvm_valid), 64'h0);

        // Rx bytes in S_WAIT are discarded
        for (int i = 0; i < 3; i++) send_byte(8'($urandom));
        chk("wait_rx_k", 64'(k_out), 64'h4321);
        chk("wait_rx_x", 64'(x_out), 64'h65);
        chk("wait_busy", 64'(busy), 64'h1);

        // Result send with 3 stall cycles on first byte
        y_in    = {8'hA5, 8'h3C};
        y_valid = 1'b1;
        tick();
        y_valid  = 1'b0;
        tx_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("res_hold_valid", 64'(tx_valid), 64'h1);
            chk("res_hold_data", 64'(tx_data), 64'h3C);
            tick();
        end
        tx_ready = 1'b1;
        chk("res_b0_data", 64'(tx_data), 64'h3C);
        tick();
        chk("res_b1_valid", 64'(tx_valid), 64'h1);
        chk("res_b1_data", 64'(tx_data), 64'hA5);
        tick();
        tx_ready = 1'b0;
        chk("res_end_valid", 64'(tx_valid), 64'h0);
        chk("res_end_busy", 64'(busy), 64'h0);

        // Backpressure on start: 5 stall cycles, fresh frame loads from index 0
        rand_frame();
        model_frame();
        send_range(0, 6);
        for (int i = 0; i < 5; i++) begin
            chk("bp_mvm_valid", 64'(mvm_valid), 64'h1);
            chk("bp_busy", 64'(busy), 64'h1);
            chk("bp_k", 64'(k_out), 64'(exp_k));
            chk("bp_x", 64'(x_out), 64'(exp_x));
            tick();
        end
        mvm_ready = 1'b1;
        chk("bp_mvm_valid_6", 64'(mvm_valid), 64'h1);
        tick();
        mvm_ready = 1'b0;
        chk("bp_mvm_valid_off", 64'(mvm_valid), 64'h0);
        do_result("bp_res", 16'($urandom));

        // Randomized frames and results
        for (int it = 0; it < 6; it++) begin
            y_in    = 16'($urandom);
            y_valid = 1'b1;
            tick();
            y_valid = 1'b0;
            chk("rnd_y_ignored_busy", 64'(busy), 64'h0);
            rand_frame();
            model_frame();
            send_range(0, 6);
            do_start("rnd_start");
            k_keep = exp_k;
            x_keep = exp_x;
            for (int i = 0; i < int'($urandom_range(0, 3)); i++) send_byte(8'($urandom));
            chk("rnd_wait_k", 64'(k_out), 64'(k_keep));
            chk("rnd_wait_x", 64'(x_out), 64'(x_keep));
            do_result("rnd_res", 16'($urandom));
        end

        // Reset after 3 bytes
        rand_frame();
        send_range(0, 3);
        rstn = 1'b0;
        tick();
        check_reset_outs("rst_mid");
        rstn = 1'b1;
        rand_frame();
        model_frame();
        send_range(0, 6);
        chk("rst_mid_k", 64'(k_out), 64'(exp_k));
        chk("rst_mid_x", 64'(x_out), 64'(exp_x));
        do_start("rst_mid_start");

        // Reset during S_SEND
        y_in    = 16'hBEEF;
        y_valid = 1'b1;
        tick();
        y_valid = 1'b0;
        chk("rst_send_active", 64'(tx_valid), 64'h1);
        rstn = 1'b0;
        tick();
        check_reset_outs("rst_send");
        rstn = 1'b1;
        rand_frame();
        model_frame();
        send_range(0, 6);
        chk("rst_send_k", 64'(k_out), 64'(exp_k));
        chk("rst_send_x", 64'(x_out), 64'(exp_x));
        do_start("rst_send_start");
        do_result("rst_send_res", 16'($urandom));

        // Idle gap after a partial frame
        rand_frame();
        send_range(0, 2);
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            if (err_timeout === 1'b1) pulses++;
            tick();
        end
`ifdef MVM_CTRL_TIMEOUT_EN
        chk("to_pulses", 64'(pulses), 64'h1);
        rand_frame();
        model_frame();
        send_range(0, 6);
        chk("to_restart_mvm_valid", 64'(mvm_valid), 64'h1);
        chk("to_restart_k", 64'(k_out), 64'(exp_k));
        chk("to_restart_x", 64'(x_out), 64'(exp_x));
`else
        chk("to_pulses", 64'(pulses), 64'h0);
        model_frame();
        send_range(2, 6);
        chk("to_resume_mvm_valid", 64'(mvm_valid), 64'h1);
        chk("to_resume_k", 64'(k_out), 64'(exp_k));
        chk("to_resume_x", 64'(x_out), 64'(exp_x));
`endif
        do_start("to_start");
        do_result("to_res", 16'($urandom));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
